button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of independent push-button channels, at least 1.
REQ-002 Parameter DB_CYCLES, default 16: number of consecutive stable cycles required to accept a level change, at least 1.
REQ-003 Parameter LONG_CYCLES, default 1000: cycles from press_pulse to long_pulse, at least 2.
REQ-004 Parameter REPEAT_CYCLES, default 200: auto-repeat period while held, at least 1.
REQ-005 Port clk, input, 1 bit: single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port pb, input, N_CH bits: raw asynchronous button inputs, active high.
REQ-008 Port repeat_en, input, N_CH bits: per-channel auto-repeat enable.
REQ-009 Port level, output, N_CH bits: debounced button level.
REQ-010 Port press_pulse, output, N_CH bits: one-cycle pulse on an accepted rising edge of level.
REQ-011 Port release_pulse, output, N_CH bits: one-cycle pulse on an accepted falling edge of level.
REQ-012 Port long_pulse, output, N_CH bits: one-cycle pulse when a press has been held for LONG_CYCLES.
REQ-013 Port repeat_pulse, output, N_CH bits: auto-repeat pulses while held.

Function
REQ-014 Channels SHALL be fully independent; bit i of each output SHALL depend only on pb[i] and repeat_en[i].
REQ-015 Each pb bit SHALL pass through a 2-flop synchronizer; the second flop is called sync.
REQ-016 The debounce counter SHALL be $clog2(DB_CYCLES+1) bits wide.
REQ-017 The debounce counter SHALL increment on each cycle where sync differs from level.
REQ-018 The debounce counter SHALL clear on any cycle where sync equals level.
REQ-019 When the debounce counter reaches DB_CYCLES, level SHALL toggle and the counter SHALL clear.
REQ-020 Latency: after a clean input change first sampled at edge k, level SHALL change at edge k+DB_CYCLES+1.
REQ-021 Latency: press_pulse or release_pulse SHALL be high for exactly the one cycle following edge k+DB_CYCLES+2.
REQ-022 A glitch shorter than DB_CYCLES sampled cycles SHALL produce no level change and no pulse.
REQ-023 The per-channel FSM SHALL have three states: IDLE (level 0), PRESS (level 1, timing), HELD (level 1, long press reached).
REQ-024 FSM transition IDLE->PRESS SHALL occur with press_pulse.
REQ-025 FSM transition PRESS->HELD SHALL occur when the hold timer expires, asserting long_pulse exactly LONG_CYCLES cycles after press_pulse.
REQ-026 FSM transitions PRESS->IDLE and HELD->IDLE SHALL occur with release_pulse.
REQ-027 If release and timer expiry fall on the same cycle, release SHALL win: the FSM goes to IDLE with no long_pulse.
REQ-028 In HELD with repeat_en high, repeat_pulse SHALL coincide with long_pulse and then recur every REPEAT_CYCLES cycles.
REQ-029 Deasserting repeat_en SHALL suppress repeat_pulse immediately.
REQ-030 Reasserting repeat_en while in HELD SHALL produce the next repeat_pulse REPEAT_CYCLES cycles later.
REQ-031 The hold timer SHALL be $clog2(max(LONG_CYCLES,REPEAT_CYCLES)+1) bits wide, SHALL never wrap, and SHALL clear on every state change.
REQ-032 press_pulse and release_pulse SHALL never be high together on the same channel.
REQ-033 long_pulse SHALL be asserted at most once per press.

Reset
REQ-034 While rst_n is low, synchronizers, counters and level SHALL be 0, every FSM SHALL be in IDLE, and all pulse outputs SHALL be 0, independent of clk.
REQ-035 If reset is asserted while a button is held, no release_pulse SHALL be generated.
REQ-036 After reset, a still-pressed button SHALL be debounced afresh and SHALL produce a new press_pulse.

Structure
REQ-037 Package btn_pkg SHALL hold the FSM state enum (IDLE, PRESS, HELD) and the counter-width helper function.
REQ-038 Sub-module btn_channel SHALL implement one channel; the top level SHALL instantiate it N_CH times in a generate loop.

Verification (N_CH=2, DB_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3)
REQ-039 pb[0] 0->1 held stable -> level[0] rises at edge k+5, press_pulse[0] is high one cycle after edge k+6, and channel 1 is unchanged.
REQ-040 pb[0] pulses of 3 cycles high separated by 1 cycle low, repeated -> level, press_pulse and release_pulse all stay 0.
REQ-041 Hold 25 cycles after press_pulse with repeat_en=1 -> long_pulse at +10; repeat_pulse at +10, +13, +16, +19, +22; then on release, a single release_pulse and no further pulses.
REQ-042 Release timed so level falls on the timer-expiry cycle -> release_pulse only, no long_pulse.
REQ-043 rst_n pulled low mid-HELD, then released with pb still high -> outputs go to 0 immediately and no release_pulse occurs; after 5 edges level is 1 and a fresh press_pulse occurs.
REQ-044 Both channels pressed simultaneously with repeat_en=2'b01 -> identical press and long timing on both channels; repeat_pulse appears on channel 0 only.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } btn_state_t;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debouncer and press/hold/repeat FSM.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = 16,
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W  = cnt_width(DB_CYCLES);
    localparam int TMR_W = cnt_width(max2(LONG_CYCLES, REPEAT_CYCLES));

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [DB_W-1:0]  db_cnt;
    logic [TMR_W-1:0] timer;
    logic             rep_q;
    btn_state_t       state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= pb;
            sync <= meta;
        end
    end

    // Toggle on the cycle the count would reach DB_CYCLES, so the counter never holds that value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= ~level;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            rep_q         <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            rep_q         <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (level) begin
                        state       <= PRESS;
                        press_pulse <= 1'b1;
                    end
                end
                // Release is tested first so it wins over a coincident timer expiry.
                PRESS: begin
                    if (!level) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        timer         <= '0;
                    end else if (timer == LONG_LAST) begin
                        state      <= HELD;
                        long_pulse <= 1'b1;
                        rep_q      <= repeat_en;
                        timer      <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HELD: begin
                    if (!level) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        timer         <= '0;
                    end else if (!repeat_en) begin
                        timer <= '0;
                    end else if (timer == REP_LAST) begin
                        rep_q <= 1'b1;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    // Gated by the live enable so dropping repeat_en silences the output at once.
    assign repeat_pulse = rep_q & repeat_en;

endmodule

// File: rtl/button_conditioner.sv
// N_CH independent push-button conditioners with debounce, long-press and auto-repeat.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int DB_CYCLES     = 16,
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pb,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .pb           (pb[i]),
            .repeat_en    (repeat_en[i]),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .long_pulse   (long_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: per-cycle expected output words from press/release event timing.
module tb_button_conditioner;

    localparam int N_CH = 2;
    localparam int DB   = 4;
    localparam int LC   = 10;
    localparam int RC   = 3;
    localparam int W    = 5 * N_CH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] pb = '0;
    logic [N_CH-1:0] repeat_en = '0;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] long_pulse;
    logic [N_CH-1:0] repeat_pulse;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // Scenario description: pb[c] high for edges pr[c] .. rl[c]-1 (pr=0: idle, rl=0: never released).
    int pr[N_CH];
    int rl[N_CH];
    logic [N_CH-1:0] rep;
    bit glitch;

    button_conditioner #(
        .N_CH         (N_CH),
        .DB_CYCLES    (DB),
        .LONG_CYCLES  (LC),
        .REPEAT_CYCLES(RC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pb           (pb),
        .repeat_en    (repeat_en),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic pb_val(input int c, input int e);
        if (glitch && c == 0)
            return (e >= 1 && e <= 20 && ((e - 1) % 4) != 3);
        return (pr[c] != 0 && e >= pr[c] && (rl[c] == 0 || e < rl[c]));
    endfunction

    // Expected outputs after edge e, from the latency rules: level at pr+DB+1, press at pr+DB+2, etc.
    function automatic logic [W-1:0] exp_word(input int e);
        logic [N_CH-1:0] lv, pp, rp, lp, rpp;
        lv = '0; pp = '0; rp = '0; lp = '0; rpp = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (!glitch && pr[c] != 0) begin
                int p_e;
                int q_e;
                bit hl;
                p_e = pr[c] + DB + 2;
                q_e = (rl[c] == 0) ? 1000000 : rl[c] + DB + 2;
                hl  = (q_e > p_e + LC);
                lv[c]  = (e >= p_e - 1) && (e < q_e - 1);
                pp[c]  = (e == p_e);
                rp[c]  = (e == q_e);
                lp[c]  = hl && (e == p_e + LC);
                rpp[c] = hl && rep[c] && (e >= p_e + LC) && (e < q_e) && (((e - p_e - LC) % RC) == 0);
            end
        end
        return {lv, pp, rp, lp, rpp};
    endfunction

    function automatic logic [W-1:0] observed();
        return {level, press_pulse, release_pulse, long_pulse, repeat_pulse};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives pb for each edge, queues the expectation, compares at the next negedge.
    task automatic run_window(input string tag, input int t);
        logic [W-1:0] exp;
        string s;
        for (int e = 1; e <= t; e++) begin
            pb = {pb_val(1, e), pb_val(0, e)};
            exp_q.push_back(exp_word(e));
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            s = $sformatf("%s_e%0d", tag, e);
            chk(s, observed(), exp);
        end
    endtask

    task automatic scenario(input string tag, input int pr0, input int rl0,
                            input int pr1, input int rl1, input logic [N_CH-1:0] rep_v, input int t);
        pr[0] = pr0; rl[0] = rl0;
        pr[1] = pr1; rl[1] = rl1;
        rep = rep_v;
        repeat_en = rep_v;
        run_window(tag, t);
    endtask

    initial begin
        glitch = 1'b0;
        pr[0] = 0; pr[1] = 0; rl[0] = 0; rl[1] = 0;
        rep = '0;
        #12;
        chk("reset_idle", observed(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short press on ch0 only: no long press, ch1 stays quiet.
        scenario("short", 1, 8, 0, 0, 2'b00, 16);

        // 3-high / 1-low bursts never reach the debounce threshold.
        glitch = 1'b1;
        scenario("glitch", 0, 0, 0, 0, 2'b00, 24);
        glitch = 1'b0;

        // Long hold with auto-repeat; release lands 25 cycles after press_pulse.
        scenario("hold_rep", 1, 26, 0, 0, 2'b01, 34);

        // ch0 release coincides with expiry (release wins); ch1 releases one cycle later.
        scenario("race", 1, 11, 1, 12, 2'b11, 20);

        // Simultaneous presses, repeat enabled on ch0 only.
        scenario("dual", 1, 20, 1, 20, 2'b01, 28);

        // Reach HELD, then reset asynchronously with the button still down.
        scenario("pre_rst", 1, 0, 0, 0, 2'b01, 20);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", observed(), '0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold", observed(), '0);
        rst_n = 1'b1;
        scenario("post_rst", 1, 5, 0, 0, 2'b00, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
